// File: rtl/urv_imem_wb_bridge_if.sv
// Fetch-port and Wishbone signals of the uRV instruction-memory bridge.
// 'master' is the bridge (the Wishbone master); 'slave' is the fetch stage plus bus environment.
interface urv_imem_wb_bridge_if;
  logic [31:0] im_addr_i;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    input  im_addr_i, wb_dat_i, wb_ack_i, wb_err_i,
    output im_data_o, im_valid_o, wb_cyc_o, wb_stb_o, wb_adr_o
  );
  modport slave (
    output im_addr_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  im_data_o, im_valid_o, wb_cyc_o, wb_stb_o, wb_adr_o
  );
endinterface

// File: rtl/urv_imem_wb_bridge.sv
// uRV instruction-fetch responder: current word + one sequential prefetch entry,
// misses served by a single-outstanding Wishbone classic read.
module urv_imem_wb_bridge #(
  parameter bit          PREFETCH_EN = 1'b1,
  parameter logic [31:0] ERR_INSN    = 32'h0000_0000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic flush_i,
  urv_imem_wb_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH} state_t;

  state_t      state, state_nxt;
  logic [31:0] adr;
  logic        stale;
  logic        cur_vld, pre_vld, pf_q;
  logic [29:0] cur_tag, pre_tag, pf_tag;
  logic [31:0] cur_data, pre_data;
  logic [31:0] im_data;
  logic        im_valid;

  logic [29:0] a, adr_tag;
  logic        busy, bus_ack, bus_err, live;
  logic        fwd, err_fwd, cur_hit, pre_hit, miss;
  logic        issue_demand, issue_pf;

  wire unused_addr_lsb = &{1'b0, bus.im_addr_i[1:0]};

  always_comb begin
    a            = bus.im_addr_i[31:2];
    adr_tag      = adr[31:2];
    busy         = (state != IDLE);
    bus_ack      = busy & bus.wb_ack_i;
    bus_err      = busy & bus.wb_err_i & ~bus.wb_ack_i;
    // A result is usable only if no flush hit this transaction or this cycle
    live         = ~stale & ~flush_i;
    fwd          = bus_ack & live & (adr_tag == a);
    err_fwd      = bus_err & live & (adr_tag == a);
    cur_hit      = cur_vld & (cur_tag == a);
    pre_hit      = pre_vld & (pre_tag == a);
    miss         = ~cur_hit & ~pre_hit;
    issue_demand = (state == IDLE) & ~flush_i & miss;
    // A pre hit re-queues the prefetch this edge, so the old queue entry must not issue
    issue_pf     = (state == IDLE) & ~flush_i & cur_hit & pf_q & PREFETCH_EN;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue_demand)  state_nxt = DEMAND;
        else if (issue_pf) state_nxt = PREFETCH;
      end
      DEMAND, PREFETCH: begin
        if (bus.wb_ack_i || bus.wb_err_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      adr      <= '0;
      stale    <= 1'b0;
      cur_vld  <= 1'b0;
      pre_vld  <= 1'b0;
      pf_q     <= 1'b0;
      cur_tag  <= '0;
      pre_tag  <= '0;
      pf_tag   <= '0;
      cur_data <= '0;
      pre_data <= '0;
      im_data  <= '0;
      im_valid <= 1'b0;
    end else begin
      if (flush_i) begin
        im_valid <= 1'b0;
      end else if (fwd) begin
        im_data  <= bus.wb_dat_i;
        im_valid <= 1'b1;
      end else if (err_fwd) begin
        im_data  <= ERR_INSN;
        im_valid <= 1'b1;
      end else if (cur_hit) begin
        im_data  <= cur_data;
        im_valid <= 1'b1;
      end else if (pre_hit) begin
        im_data  <= pre_data;
        im_valid <= 1'b1;
        cur_vld  <= 1'b1;
        cur_tag  <= pre_tag;
        cur_data <= pre_data;
        pre_vld  <= 1'b0;
        pf_q     <= 1'b1;
        pf_tag   <= a + 30'd1;
      end else begin
        im_valid <= 1'b0;
      end

      if (issue_demand) begin
        adr   <= {a, 2'b00};
        stale <= 1'b0;
        pf_q  <= 1'b0;
      end else if (issue_pf) begin
        adr   <= {pf_tag, 2'b00};
        stale <= 1'b0;
        pf_q  <= 1'b0;
      end else if (busy && flush_i) begin
        stale <= 1'b1;
      end

      if (bus_ack && live) begin
        if (state == DEMAND) begin
          cur_vld  <= 1'b1;
          cur_tag  <= adr_tag;
          cur_data <= bus.wb_dat_i;
          pre_vld  <= 1'b0;
          pf_q     <= 1'b1;
          pf_tag   <= adr_tag + 30'd1;
        end else begin
          pre_vld  <= 1'b1;
          pre_tag  <= adr_tag;
          pre_data <= bus.wb_dat_i;
        end
      end

      if (flush_i) begin
        cur_vld <= 1'b0;
        pre_vld <= 1'b0;
        pf_q    <= 1'b0;
      end
    end
  end

  assign bus.im_data_o  = im_data;
  assign bus.im_valid_o = im_valid;
  assign bus.wb_cyc_o   = busy;
  assign bus.wb_stb_o   = busy;
  assign bus.wb_adr_o   = adr;
endmodule
